// File: rtl/riscv_multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its RV32I datapath.
// The controller is the master: it reads the IR fields and Z and drives every enable and select.
interface riscv_multicycle_ctrl_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Z;
    logic       PC_wren;
    logic       IR_wren;
    logic       mem_wren;
    logic       regfile_wren;
    logic       addr_sel;
    logic [1:0] ALU_asel;
    logic [1:0] ALU_bsel;
    logic [1:0] result_sel;
    logic [1:0] ximm_sel;
    logic [2:0] ALU_control;
    logic       illegal_instr;

    modport master (
        input  opcode, funct3, funct7b5, Z,
        output PC_wren, IR_wren, mem_wren, regfile_wren, addr_sel,
               ALU_asel, ALU_bsel, result_sel, ximm_sel, ALU_control, illegal_instr
    );
    modport slave (
        output opcode, funct3, funct7b5, Z,
        input  PC_wren, IR_wren, mem_wren, regfile_wren, addr_sel,
               ALU_asel, ALU_bsel, result_sel, ximm_sel, ALU_control, illegal_instr
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Moore FSM sequencing a shared-ALU, single-memory multicycle RV32I datapath.
// Memory states hold for MEM_LAT extra cycles; enables fire only on the final one.
module riscv_multicycle_ctrl #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    riscv_multicycle_ctrl_if.master       bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_EXEC_I   = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_JAL      = 4'd9;
    localparam logic [3:0] S_BEQ      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    logic [3:0] state_q, state_d;
    logic [3:0] wait_q,  wait_d;
    logic       last;

    assign last = (wait_q == LAT);

    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_dec = sub ? 3'b001 : 3'b000;
            3'b110:  alu_dec = 3'b011;
            3'b111:  alu_dec = 3'b010;
            3'b010:  alu_dec = 3'b101;
            default: alu_dec = 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = 4'd0;
        case (state_q)
            S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                if (last) begin
                    case (state_q)
                        S_FETCH:   state_d = S_DECODE;
                        S_MEMREAD: state_d = S_MEMWB;
                        default:   state_d = S_FETCH;
                    endcase
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_JAL:       state_d = S_JAL;
                    OP_BR:        state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:           state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
            S_JAL:              state_d = S_ALUWB;
            default:            state_d = S_FETCH;
        endcase
    end

    // Outputs are forced low while reset is high so an abort never leaks a write.
    always_comb begin
        bus.PC_wren       = 1'b0;
        bus.IR_wren       = 1'b0;
        bus.mem_wren      = 1'b0;
        bus.regfile_wren  = 1'b0;
        bus.addr_sel      = 1'b0;
        bus.ALU_asel      = 2'b00;
        bus.ALU_bsel      = 2'b00;
        bus.result_sel    = 2'b00;
        bus.ximm_sel      = 2'b00;
        bus.ALU_control   = 3'b000;
        bus.illegal_instr = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.ALU_bsel   = 2'b10;
                    bus.result_sel = 2'b10;
                    bus.IR_wren    = last;
                    bus.PC_wren    = last;
                end
                S_DECODE: begin
                    bus.ALU_asel = 2'b01;
                    bus.ALU_bsel = 2'b01;
                    bus.ximm_sel = (bus.opcode == OP_JAL) ? 2'b11 : 2'b10;
                    case (bus.opcode)
                        OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR: bus.illegal_instr = 1'b0;
                        default:                                bus.illegal_instr = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    bus.ALU_asel = 2'b10;
                    bus.ALU_bsel = 2'b01;
                    bus.ximm_sel = bus.opcode[5] ? 2'b01 : 2'b00;
                end
                S_MEMREAD:  bus.addr_sel = 1'b1;
                S_MEMWB: begin
                    bus.result_sel   = 2'b01;
                    bus.regfile_wren = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.addr_sel = 1'b1;
                    bus.mem_wren = last;
                end
                S_EXEC_R: begin
                    bus.ALU_asel    = 2'b10;
                    bus.ALU_control = alu_dec(bus.funct3, bus.funct7b5);
                end
                S_EXEC_I: begin
                    bus.ALU_asel    = 2'b10;
                    bus.ALU_bsel    = 2'b01;
                    bus.ALU_control = alu_dec(bus.funct3, 1'b0);
                end
                S_ALUWB:    bus.regfile_wren = 1'b1;
                S_JAL: begin
                    bus.ALU_asel = 2'b01;
                    bus.ALU_bsel = 2'b10;
                    bus.PC_wren  = 1'b1;
                end
                S_BEQ: begin
                    bus.ALU_asel    = 2'b10;
                    bus.ALU_control = 3'b001;
                    bus.PC_wren     = ((bus.funct3 == 3'b000) &  bus.Z) |
                                      ((bus.funct3 == 3'b001) & ~bus.Z);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for the multicycle controller at MEM_LAT = 0, 1 and 2.
// All three instances see the same IR fields; each test watches the one whose latency it needs.
module tb_riscv_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ir = 32'h0;
    logic        z = 1'b0;
    int          checks = 0;
    int          failures = 0;

    riscv_multicycle_ctrl_if if0 ();
    riscv_multicycle_ctrl_if if1 ();
    riscv_multicycle_ctrl_if if2 ();

    riscv_multicycle_ctrl #(.MEM_LAT(0)) u0 (.clk(clk), .reset(reset), .bus(if0));
    riscv_multicycle_ctrl #(.MEM_LAT(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
    riscv_multicycle_ctrl #(.MEM_LAT(2)) u2 (.clk(clk), .reset(reset), .bus(if2));

    always #5 clk = ~clk;

    assign if0.opcode = ir[6:0];   assign if0.funct3 = ir[14:12];
    assign if0.funct7b5 = ir[30];  assign if0.Z = z;
    assign if1.opcode = ir[6:0];   assign if1.funct3 = ir[14:12];
    assign if1.funct7b5 = ir[30];  assign if1.Z = z;
    assign if2.opcode = ir[6:0];   assign if2.funct3 = ir[14:12];
    assign if2.funct7b5 = ir[30];  assign if2.Z = z;

    // {PC,IR,mem,rf wren, addr_sel, asel, bsel, result_sel, ximm_sel, ALU_control, illegal}
    logic [16:0] o0, o1, o2;
    assign o0 = {if0.PC_wren, if0.IR_wren, if0.mem_wren, if0.regfile_wren, if0.addr_sel,
                 if0.ALU_asel, if0.ALU_bsel, if0.result_sel, if0.ximm_sel, if0.ALU_control, if0.illegal_instr};
    assign o1 = {if1.PC_wren, if1.IR_wren, if1.mem_wren, if1.regfile_wren, if1.addr_sel,
                 if1.ALU_asel, if1.ALU_bsel, if1.result_sel, if1.ximm_sel, if1.ALU_control, if1.illegal_instr};
    assign o2 = {if2.PC_wren, if2.IR_wren, if2.mem_wren, if2.regfile_wren, if2.addr_sel,
                 if2.ALU_asel, if2.ALU_bsel, if2.result_sel, if2.ximm_sel, if2.ALU_control, if2.illegal_instr};

    function automatic logic [16:0] V(input logic pc, ir_w, mw, rw, as,
                                      input logic [1:0] a, b, r, x,
                                      input logic [2:0] alu, input logic ill);
        return {pc, ir_w, mw, rw, as, a, b, r, x, alu, ill};
    endfunction

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [31:0] instr);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 ir = instr;
        reset = 1'b0;
    endtask

    logic [16:0] F_LAST, F_WAIT, DEC_B, DEC_J, ALUWB, MEMWB, MADR_L, MADR_S, MRD, MWR, MWR_L, EXR_ADD;

    initial begin
        F_LAST  = V(1,1,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0);
        F_WAIT  = V(0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0);
        DEC_B   = V(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 0);
        DEC_J   = V(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b11, 3'b000, 0);
        ALUWB   = V(0,0,0,1,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
        MEMWB   = V(0,0,0,1,0, 2'b00,2'b00,2'b01,2'b00, 3'b000, 0);
        MADR_L  = V(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000, 0);
        MADR_S  = V(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01, 3'b000, 0);
        MRD     = V(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
        MWR     = V(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
        MWR_L   = V(0,0,1,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0);
        EXR_ADD = V(0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b000, 0);

        // reset holds every output low
        nxt();
        chk("reset_u0", o0, 17'h0);
        chk("reset_u2", o2, 17'h0);

        // add at MEM_LAT=0
        do_reset(32'h00208033);
        nxt(); chk("add_c1_fetch", o0, F_LAST);
        nxt(); chk("add_c2_decode", o0, DEC_B);
        nxt(); chk("add_c3_execr", o0, EXR_ADD);
        nxt(); chk("add_c4_aluwb", o0, ALUWB);
        nxt(); chk("add_c5_fetch", o0, F_LAST);

        // sub / slt / or in EXEC_R
        do_reset(32'h40208033);
        nxt(); nxt(); nxt(); chk("sub_alu", 17'(if0.ALU_control), 17'(3'b001));
        do_reset(32'h0020A033);
        nxt(); nxt(); nxt(); chk("slt_alu", 17'(if0.ALU_control), 17'(3'b101));
        do_reset(32'h0020E033);
        nxt(); nxt(); nxt(); chk("or_alu", 17'(if0.ALU_control), 17'(3'b011));
        do_reset(32'h0020F033);
        nxt(); nxt(); nxt(); chk("and_alu", 17'(if0.ALU_control), 17'(3'b010));
        do_reset(32'h0020B033);
        nxt(); nxt(); nxt(); chk("r_bad_f3_alu", 17'(if0.ALU_control), 17'(3'b000));

        // addi with instr[30]=1 stays add in EXEC_I
        do_reset(32'h40008093);
        nxt(); nxt(); nxt();
        chk("addi_execi", o0, V(0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000, 0));
        nxt(); chk("addi_aluwb", o0, ALUWB);

        // lw at MEM_LAT=2: 9 cycles
        do_reset(32'h0000A083);
        nxt(); chk("lw_c1", o2, F_WAIT);
        nxt(); chk("lw_c2", o2, F_WAIT);
        nxt(); chk("lw_c3", o2, F_LAST);
        nxt(); chk("lw_c4", o2, DEC_B);
        nxt(); chk("lw_c5", o2, MADR_L);
        nxt(); chk("lw_c6", o2, MRD);
        nxt(); chk("lw_c7", o2, MRD);
        nxt(); chk("lw_c8", o2, MRD);
        nxt(); chk("lw_c9", o2, MEMWB);
        nxt(); chk("lw_c10", o2, F_WAIT);

        // beq / bne at MEM_LAT=0
        z = 1'b1; do_reset(32'h00208063);
        nxt(); nxt(); nxt();
        chk("beq_z1", o0, V(1,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, 3'b001, 0));
        nxt(); chk("beq_then_fetch", o0, F_LAST);
        z = 1'b0; do_reset(32'h00208063);
        nxt(); nxt(); nxt(); chk("beq_z0_pc", 17'(if0.PC_wren), 17'd0);
        z = 1'b1; do_reset(32'h00209063);
        nxt(); nxt(); nxt(); chk("bne_z1_pc", 17'(if0.PC_wren), 17'd0);
        z = 1'b0; do_reset(32'h00209063);
        nxt(); nxt(); nxt(); chk("bne_z0_pc", 17'(if0.PC_wren), 17'd1);
        do_reset(32'h0020C063);
        nxt(); nxt(); nxt(); chk("blt_unsup_pc", 17'(if0.PC_wren), 17'd0);

        // jal at MEM_LAT=0
        do_reset(32'h0000006F);
        nxt();
        nxt(); chk("jal_decode", o0, DEC_J);
        nxt(); chk("jal_state", o0, V(1,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 3'b000, 0));
        nxt(); chk("jal_aluwb", o0, ALUWB);

        // sw at MEM_LAT=1: mem_wren only on cycle 6
        do_reset(32'h0020A023);
        nxt(); chk("sw_c1", o1, F_WAIT);
        nxt(); chk("sw_c2", o1, F_LAST);
        nxt(); chk("sw_c3", o1, DEC_B);
        nxt(); chk("sw_c4", o1, MADR_S);
        nxt(); chk("sw_c5", o1, MWR);
        nxt(); chk("sw_c6", o1, MWR_L);
        nxt(); chk("sw_c7", o1, F_WAIT);

        // illegal opcode
        do_reset(32'h0000007F);
        nxt();
        nxt(); chk("ill_decode", o0, V(0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 1));
        nxt(); chk("ill_fetch", o0, F_LAST);

        // async reset during MEMREAD (lw at MEM_LAT=2, cycle 6)
        do_reset(32'h0000A083);
        for (int i = 0; i < 6; i++) nxt();
        chk("abort_pre_memread", o2, MRD);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 chk("abort_u2_zero", o2, 17'h0);
        chk("abort_u1_zero", o1, 17'h0);
        nxt();
        @(posedge clk);
        #1 reset = 1'b0;
        nxt(); chk("abort_fetch_c1", o2, F_WAIT);
        nxt(); chk("abort_fetch_c2", o2, F_WAIT);
        nxt(); chk("abort_fetch_c3", o2, F_LAST);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
